// File: rtl/fxp_var_shifter_pipe.sv
// Pipelined signed variable shifter: left shift or arithmetic right shift with optional rounding.
// Define FXP_VSHIFT_SAT_EN to add left-shift overflow detection, saturation and out_sat.
module fxp_var_shifter_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHIFT_W = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               shift_sign,
    input  logic               in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sat
);
    localparam int NSTG = $clog2(WIDTH);
    // One guard bit below the LSB: right shifts land floor(x / 2^(s-1)) here, so the
    // final rounding step is a halving with the guard bit as carry-in.
    localparam int DW = WIDTH + 1;

    logic            adv;
    logic            big;
    logic [NSTG-1:0] vld_q, vld_d, rgt_q, rgt_d, rnd_q, rnd_d;
    logic [DW-1:0]   dat_q [NSTG];
    logic [DW-1:0]   dat_d [NSTG];
    logic [NSTG-1:0] amt_q [NSTG-1];
    logic [NSTG-1:0] amt_d [NSTG-1];

    // Stage inputs: index 0 is the entry port, index k is the register of stage k-1.
    logic [NSTG-1:0] src_vld, src_rgt, src_rnd;
    logic [DW-1:0]   src_dat [NSTG];
    logic [NSTG-1:0] src_amt [NSTG];
    logic [DW-1:0]   nxt_dat;
    logic [DW-1:0]   last;

`ifdef FXP_VSHIFT_SAT_EN
    logic [NSTG-1:0] ovf_q, ovf_d, neg_q, neg_d;
    logic [NSTG-1:0] src_ovf, src_neg;
    logic            nxt_ovf;

    function automatic logic top_ovf(input logic [WIDTH-1:0] d, input int k);
        logic [WIDTH-1:0] mask;
        mask = ~({WIDTH{1'b1}} >> (2**k + 1));
        return ((d & mask) != '0) && ((d & mask) != mask);
    endfunction
`endif

    assign out_valid = vld_q[NSTG-1];
    assign in_ready  = adv;

    always_comb begin
        adv     = ~vld_q[NSTG-1] | out_ready;
        big     = (in_shift >> NSTG) != '0;
        nxt_dat = '0;

        src_vld[0] = in_valid;
        src_rgt[0] = shift_sign;
        src_rnd[0] = in_round;
        src_amt[0] = in_shift[NSTG-1:0];
        src_dat[0] = {in_data, 1'b0};
        if (big) begin
            src_dat[0] = (shift_sign && !in_round) ? {DW{in_data[WIDTH-1]}} : '0;
        end
`ifdef FXP_VSHIFT_SAT_EN
        nxt_ovf    = 1'b0;
        src_neg[0] = in_data[WIDTH-1];
        src_ovf[0] = big && !shift_sign && (in_data != '0);
`endif
        for (int k = 1; k < NSTG; k++) begin
            src_vld[k] = vld_q[k-1];
            src_rgt[k] = rgt_q[k-1];
            src_rnd[k] = rnd_q[k-1];
            src_dat[k] = dat_q[k-1];
            src_amt[k] = amt_q[k-1];
`ifdef FXP_VSHIFT_SAT_EN
            src_ovf[k] = ovf_q[k-1];
            src_neg[k] = neg_q[k-1];
`endif
        end

        for (int k = 0; k < NSTG; k++) begin
            nxt_dat = src_dat[k];
`ifdef FXP_VSHIFT_SAT_EN
            nxt_ovf = src_ovf[k];
`endif
            if (src_amt[k][k]) begin
                if (src_rgt[k]) begin
                    nxt_dat = $signed(src_dat[k]) >>> (2**k);
                end else begin
                    nxt_dat = src_dat[k] << (2**k);
`ifdef FXP_VSHIFT_SAT_EN
                    if (top_ovf(src_dat[k][DW-1:1], k)) nxt_ovf = 1'b1;
`endif
                end
            end
            if (adv) begin
                vld_d[k] = src_vld[k];
                rgt_d[k] = src_rgt[k];
                rnd_d[k] = src_rnd[k];
                dat_d[k] = nxt_dat;
`ifdef FXP_VSHIFT_SAT_EN
                ovf_d[k] = nxt_ovf;
                neg_d[k] = src_neg[k];
`endif
            end else begin
                vld_d[k] = vld_q[k];
                rgt_d[k] = rgt_q[k];
                rnd_d[k] = rnd_q[k];
                dat_d[k] = dat_q[k];
`ifdef FXP_VSHIFT_SAT_EN
                ovf_d[k] = ovf_q[k];
                neg_d[k] = neg_q[k];
`endif
            end
        end

        for (int k = 0; k < NSTG - 1; k++) begin
            amt_d[k] = adv ? src_amt[k] : amt_q[k];
        end

        last = dat_q[NSTG-1];
        if (rgt_q[NSTG-1] && rnd_q[NSTG-1]) begin
            out_data = last[DW-1:1] + {{(WIDTH-1){1'b0}}, last[0]};
        end else begin
            out_data = last[DW-1:1];
        end
        out_sat = 1'b0;
`ifdef FXP_VSHIFT_SAT_EN
        if (!rgt_q[NSTG-1] && ovf_q[NSTG-1]) begin
            out_sat  = 1'b1;
            out_data = neg_q[NSTG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            rgt_q <= '0;
            rnd_q <= '0;
            for (int k = 0; k < NSTG; k++) dat_q[k] <= '0;
            for (int k = 0; k < NSTG - 1; k++) amt_q[k] <= '0;
`ifdef FXP_VSHIFT_SAT_EN
            ovf_q <= '0;
            neg_q <= '0;
`endif
        end else begin
            vld_q <= vld_d;
            rgt_q <= rgt_d;
            rnd_q <= rnd_d;
            for (int k = 0; k < NSTG; k++) dat_q[k] <= dat_d[k];
            for (int k = 0; k < NSTG - 1; k++) amt_q[k] <= amt_d[k];
`ifdef FXP_VSHIFT_SAT_EN
            ovf_q <= ovf_d;
            neg_q <= neg_d;
`endif
        end
    end
endmodule

// File: tb/tb_fxp_var_shifter_pipe.sv
// Bench for fxp_var_shifter_pipe: 32-bit streaming instance with scoreboard, plus a 16-bit instance.
`timescale 1ns/1ps
module tb_fxp_var_shifter_pipe;
`ifdef FXP_VSHIFT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, shift_sign = 1'b0, in_round = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_sat;
    logic [31:0] in_data = '0, in_shift = '0, out_data;

    logic        v16_in_valid = 1'b0, v16_sign = 1'b0, v16_round = 1'b0;
    logic        v16_in_ready, v16_out_valid, v16_out_sat;
    logic [15:0] v16_in_data = '0, v16_out_data;
    logic [7:0]  v16_in_shift = '0;

    fxp_var_shifter_pipe #(.WIDTH(32), .SHIFT_W(32)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .shift_sign(shift_sign), .in_round(in_round), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    fxp_var_shifter_pipe #(.WIDTH(16), .SHIFT_W(8)) dut16 (
        .clk(clk), .rstn(rstn), .in_valid(v16_in_valid), .in_ready(v16_in_ready),
        .in_data(v16_in_data), .in_shift(v16_in_shift), .shift_sign(v16_sign),
        .in_round(v16_round), .out_valid(v16_out_valid), .out_ready(1'b1),
        .out_data(v16_out_data), .out_sat(v16_out_sat)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] s;
        bit          rgt;
        bit          rnd;
        logic [31:0] ed;
        bit          es;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        bit          s;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          pop_cyc[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, n_pop = 0;
    logic [31:0] cur_ed = '0;
    bit          cur_es = 1'b0;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_d = '0;
    bit          hold_s = 1'b0;
    bit          done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [31:0] x, input logic [31:0] s, input bit rgt,
                                  input bit rnd, input int w, output logic [31:0] d, output bit sat);
        longint xs, r, full;
        xs  = (w == 32) ? longint'($signed(x)) : longint'($signed(x[15:0]));
        sat = 1'b0;
        if (rgt) begin
            if (s >= w)             r = rnd ? 0 : ((xs < 0) ? -1 : 0);
            else if (rnd && s != 0) r = (xs + (longint'(1) << (s - 1))) >>> s;
            else                    r = xs >>> s;
        end else begin
            if (s >= w) begin
                full = 0;
                sat  = (xs != 0);
            end else begin
                full = xs <<< s;
                sat  = (full > (longint'(1) << (w - 1)) - 1) || (full < -(longint'(1) << (w - 1)));
            end
            r = full;
            if (SAT && sat) r = (xs < 0) ? -(longint'(1) << (w - 1)) : (longint'(1) << (w - 1)) - 1;
            if (!SAT) sat = 1'b0;
        end
        d = (w == 32) ? r[31:0] : {16'h0, r[15:0]};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.x   = $urandom;
        v.s   = $urandom_range(0, 40);
        v.rgt = 1'($urandom_range(0, 1));
        v.rnd = 1'($urandom_range(0, 1));
        model(v.x, v.s, v.rgt, v.rnd, 32, v.ed, v.es);
        return v;
    endfunction

    task automatic add(input logic [31:0] x, input logic [31:0] s, input bit rgt, input bit rnd,
                       input logic [31:0] ed, input bit es);
        vec_t v;
        v.x = x; v.s = s; v.rgt = rgt; v.rnd = rnd; v.ed = ed; v.es = es;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input vec_t v);
        int guard = 0;
        in_data = v.x; in_shift = v.s; shift_sign = v.rgt; in_round = v.rnd;
        cur_ed = v.ed; cur_es = v.es; in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int g = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Scoreboard: push on accepted input, pop/compare on output transfer, check hold under stall.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            sb.delete();
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_data", out_data, hold_d);
                check("hold_sat", out_sat, hold_s);
            end
            hold_pend <= out_valid && !out_ready;
            hold_d    <= out_data;
            hold_s    <= out_sat;
            if (out_valid && out_ready) begin
                n_pop <= n_pop + 1;
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_sat", out_sat, e.s);
                    pop_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                e.d = cur_ed;
                e.s = cur_es;
                sb.push_back(e);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   npop0;
        logic [31:0] d0;

        add(32'h0000_1234, 4,  0, 0, 32'h0001_2340, 1'b0);
        add(32'hFFFF_FF00, 4,  1, 0, 32'hFFFF_FFF0, 1'b0);
        add(32'h0000_0018, 4,  1, 1, 32'h0000_0002, 1'b0);
        add(32'h8000_0000, 40, 1, 0, 32'hFFFF_FFFF, 1'b0);
        add(32'h8000_0000, 40, 1, 1, 32'h0000_0000, 1'b0);
        add(32'h4000_0000, 1,  0, 0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT);
        add(32'hFFFF_FFFF, 33, 0, 0, SAT ? 32'h8000_0000 : 32'h0000_0000, SAT);
        add(32'h1234_5678, 0,  1, 1, 32'h1234_5678, 1'b0);
        add(32'h0000_0001, 31, 0, 0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT);
        add(32'hFFFF_FFFF, 31, 1, 1, 32'h0000_0000, 1'b0);
        add(32'hFFFF_FFFF, 31, 1, 0, 32'hFFFF_FFFF, 1'b0);
        add(32'hFFFF_FFFD, 1,  1, 1, 32'hFFFF_FFFF, 1'b0);
        add(32'h0000_0003, 1,  1, 1, 32'h0000_0002, 1'b0);
        add(32'h7FFF_FFFF, 31, 1, 1, 32'h0000_0001, 1'b0);
        add(32'h8000_0000, 0,  0, 0, 32'h8000_0000, 1'b0);
        add(32'h0000_0000, 100, 0, 0, 32'h0000_0000, 1'b0);
        add(32'h1234_5678, 32'h8000_0000, 1, 0, 32'h0000_0000, 1'b0);
        add(32'hC000_0000, 1,  0, 0, 32'h8000_0000, 1'b0);
        add(32'hFFFF_FFFF, 31, 0, 0, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 20; i++) vecs.push_back(rand_vec());

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Single-beat latency
        in_data = 32'h0000_1234; in_shift = 4; shift_sign = 0; in_round = 0;
        cur_ed = 32'h0001_2340; cur_es = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("lat_accept", in_ready, 1);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("latency32", lat, 5);
        @(posedge clk); #1;
        drain();

        // Table stream, back to back
        pop_cyc.delete();
        foreach (vecs[i]) send(vecs[i]);
        drain();
        check("stream_count", pop_cyc.size(), vecs.size());
        if (pop_cyc.size() == vecs.size())
            check("stream_no_bubble", pop_cyc[pop_cyc.size()-1] - pop_cyc[0], vecs.size() - 1);

        // Three-cycle backpressure mid-stream
        fork
            begin
                for (int i = 0; i < 10; i++) send(rand_vec());
                in_valid = 1'b0;
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                d0 = out_data;
                repeat (2) begin
                    @(negedge clk);
                    check("bp_in_ready_hold", in_ready, 0);
                    check("bp_data_hold", out_data, d0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random valid and ready
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    send(rand_vec());
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_vec());
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_out_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_sat", out_sat, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        npop0 = n_pop;
        send(vecs[0]);
        send(vecs[2]);
        drain();
        check("post_rst_beats", n_pop - npop0, 2);

        // 16-bit build: latency 4, left overflow case and a rounded right shift
        @(posedge clk); #1;
        v16_in_data = 16'h00FF; v16_in_shift = 8; v16_sign = 0; v16_round = 0; v16_in_valid = 1'b1;
        @(negedge clk);
        check("w16_accept", v16_in_ready, 1);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            if (lat == 0) begin
                v16_in_data = 16'h8001; v16_in_shift = 3; v16_sign = 1; v16_round = 1;
            end else begin
                v16_in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (v16_out_valid) break;
        end
        check("latency16", lat, 4);
        check("w16_left_data", v16_out_data, SAT ? 16'h7FFF : 16'hFF00);
        check("w16_left_sat", v16_out_sat, SAT);
        @(negedge clk);
        check("w16_second_valid", v16_out_valid, 1);
        check("w16_round_data", v16_out_data, 16'hF000);
        check("w16_round_sat", v16_out_sat, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fxp_var_shifter_pipe.md
# fxp_var_shifter_pipe

Pipelined, parametrised variable shifter for signed two's-complement fixed-point streams with a valid/ready handshake. It is the successor to the combinational 32-bit variable shifter and sits in the datapath wherever a normalisation or scaling step needs a run-time shift amount. Over the earlier block it adds generic width, registered barrel stages with backpressure, round-to-nearest on right shifts, and optional left-shift saturation with an overflow flag.

## Interface
- WIDTH, 32: data width in bits; power of two, ≥ 4.
- SHIFT_W, 32: width of the shift-amount input; ≥ $clog2(WIDTH).
- NSTG (localparam), $clog2(WIDTH): number of barrel stages, which equals pipeline depth.

- clk  in  1  the single clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  signed operand.
- in_shift  in  SHIFT_W  unsigned shift amount s.
- shift_sign  in  1  0 = left shift, 1 = arithmetic right shift.
- in_round  in  1  right shift only: 1 = round to nearest (half toward +inf), 0 = floor.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  WIDTH  shifted result.
- out_sat  out  1  left-shift overflow was detected for this beat.

## Operation
- Transfer rule: a beat moves across a port when its valid and ready are both 1 in the same cycle.
- Pipeline: NSTG register stages. Stage k applies a shift of 2^k when bit k of s is set. Each stage carries valid, data, direction, round and a sticky overflow bit.
- Global advance: `adv = ~out_valid | out_ready`. All stages load together on adv; empty slots propagate as bubbles. `in_ready = adv`.
- Large shifts: `big = |in_shift[SHIFT_W-1:NSTG]` is decoded at entry.
- Right shift, floor: result = x >>> s. If big, the result is all sign bits (0 or −1).
- Right shift, round: result = (x + 2^(s−1)) >>> s for s ≥ 1, evaluated at WIDTH+1 bits so the add cannot overflow. For s = 0, result = x. If big or s ≥ WIDTH, result = 0.
- Left shift: result = x << s, zero fill.
- Overflow is sticky across stages. Stage k with shift bit set flags overflow if the top 2^k+1 bits of its input are not all equal. If big, overflow = (x ≠ 0) and the data is forced to 0.
- out_sat is the sticky overflow bit on left shifts and is always 0 on right shifts.
- Saturated left-shift value: see Configuration.

## Timing
- Latency is exactly NSTG cycles from an accepted input to out_valid when out_ready is held at 1. With WIDTH = 32 this is 5 cycles.
- Throughput is one beat per cycle with no bubbles under continuous valid and ready.
- Backpressure: while out_valid=1 and out_ready=0, every stage holds and in_ready=0. out_data and out_sat stay stable until the transfer.
- Simultaneous output transfer and input accept in one cycle is legal; the pipeline shifts by one slot.
- The in_ready to out_ready path is combinational by design. No skid buffer is provided.
- Reset: all stage valid bits clear asynchronously, so out_valid=0, out_data=0 and out_sat=0. in_ready=1 once rstn is released.
- Reset mid-operation discards all in-flight beats. No partial output appears.

## Configuration
- FXP_VSHIFT_SAT_EN defined:
  - An overflowing left shift outputs the clamp value {0,1…1} for x ≥ 0 or {1,0…0} for x < 0.
  - out_sat = 1 for that beat.
- FXP_VSHIFT_SAT_EN not defined:
  - An overflowing left shift outputs the wrapped x << s (0 if big).
  - out_sat is tied to 0, and the overflow logic is removed.

## Test plan
- Stream with WIDTH=32, out_ready=1: x=0x0000_1234, s=4, left → 0x0001_2340 five cycles later, out_sat=0. Back-to-back beats appear on consecutive cycles.
- Right shift: x=0xFFFF_FF00, s=4, floor → 0xFFFF_FFF0. x=0x0000_0018, s=4, round → 0x0000_0002. x=0x8000_0000, s=40, floor → 0xFFFF_FFFF; same with round → 0.
- Left-shift overflow: x=0x4000_0000, s=1.
  - With FXP_VSHIFT_SAT_EN: 0x7FFF_FFFF, out_sat=1.
  - Without: 0x8000_0000, out_sat=0.
  - x=−1, s=33 with the macro defined: 0x8000_0000, out_sat=1.
- Backpressure: drop out_ready for 3 cycles mid-stream. in_ready falls the same cycle, out_data holds, and no beat is lost or duplicated.
- Reset with 3 beats in flight: out_valid=0 immediately. After rstn rises, only new beats emerge.
- WIDTH=16 build: latency is 4 cycles. x=0x00FF, s=8, left → 0xFF00, and overflow is flagged per configuration.
